// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the host UART message link.
// Word order, default geometry and the TX FSM state enum.
package uart_msg_pkg;

  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_WORDS_PER_PACKET = 4;
  localparam int MSG_WIDTH =
    DEF_WORD_SIZE * DEF_WORDS_PER_PACKET;

  // Words go out and come in most significant first.
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RESP
  } tx_state_e;

endpackage

// File: rtl/msg_rx_framer.sv
// Reassembles received UART words into response messages.
// Ports: clk, reset (async, active-high); rx_valid/rx_data
// from uart_rx; resp_data/resp_valid assembled message and
// strobe; frag_drop pulses when a partial message times out.
module msg_rx_framer
  import uart_msg_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int WORDS_PER_PACKET = DEF_WORDS_PER_PACKET,
  parameter int INTERBYTE_TIMEOUT = 1200
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_valid,
  input  logic [WORD_SIZE-1:0] rx_data,
  output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] resp_data,
  output logic resp_valid,
  output logic frag_drop
);

  localparam int MW = WORD_SIZE * WORDS_PER_PACKET;
  localparam int SW = MW - WORD_SIZE;
  localparam int IW = $clog2(WORDS_PER_PACKET + 1);
  localparam int GW = $clog2(INTERBYTE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(WORDS_PER_PACKET - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(INTERBYTE_TIMEOUT - 1);

  logic [SW-1:0] sh_q;
  logic [IW-1:0] idx_q;
  logic [GW-1:0] gap_q;
  logic [MW-1:0] resp_q;
  logic resp_valid_q;
  logic frag_q;
  logic [MW-1:0] cat;

  // Earlier words plus the incoming one, oldest on top.
  assign cat = {sh_q, rx_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q <= '0;
      idx_q <= '0;
      gap_q <= '0;
      resp_q <= '0;
      resp_valid_q <= 1'b0;
      frag_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      frag_q <= 1'b0;
      // A word on the expiry cycle is kept, so rx_valid
      // is tested before the gap limit.
      if (rx_valid) begin
        gap_q <= '0;
        if (idx_q == IDX_LAST) begin
          resp_q <= cat;
          resp_valid_q <= 1'b1;
          idx_q <= '0;
        end else begin
          sh_q <= cat[SW-1:0];
          idx_q <= idx_q + 1'b1;
        end
      end else if (idx_q != '0) begin
        if (gap_q == GAP_LAST) begin
          idx_q <= '0;
          gap_q <= '0;
          frag_q <= 1'b1;
        end else begin
          gap_q <= gap_q + 1'b1;
        end
      end
    end
  end

  assign resp_data = resp_q;
  assign resp_valid = resp_valid_q;
  assign frag_drop = frag_q;

endmodule

// File: rtl/host_msg_port.sv
// Host endpoint of the UART message link: sends one command
// message as words and waits, with a timeout, for the reply.
// Ports: clk, reset (async, active-high); cmd_data/cmd_valid/
// cmd_ready command handshake; tx_ready/tx_start/tx_data to
// uart_tx; rx_valid/rx_data from uart_rx; resp_data,
// resp_valid, resp_timeout, frag_drop pulses; busy when the
// TX FSM is not idle.
module host_msg_port
  import uart_msg_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int WORDS_PER_PACKET = DEF_WORDS_PER_PACKET,
  parameter int INTERBYTE_TIMEOUT = 1200,
  parameter int RESP_TIMEOUT = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic [WORD_SIZE*WORDS_PER_PACKET-1:0] cmd_data,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic tx_ready,
  output logic tx_start,
  output logic [WORD_SIZE-1:0] tx_data,
  input  logic rx_valid,
  input  logic [WORD_SIZE-1:0] rx_data,
  output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] resp_data,
  output logic resp_valid,
  output logic resp_timeout,
  output logic frag_drop,
  output logic busy
);

  localparam int MW = WORD_SIZE * WORDS_PER_PACKET;
  localparam int WCW = $clog2(WORDS_PER_PACKET + 1);
  localparam int RCW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [WCW-1:0] WC_LAST =
    WCW'(WORDS_PER_PACKET - 1);
  localparam logic [RCW-1:0] RC_LAST =
    RCW'(RESP_TIMEOUT - 1);

  tx_state_e state_q;
  logic [MW-1:0] sh_q;
  logic [WCW-1:0] wcnt_q;
  logic [RCW-1:0] rcnt_q;
  logic arm_q;
  logic low_q;
  logic rdy_q;
  logic start_q;
  logic [WORD_SIZE-1:0] txd_q;
  logic to_q;

  logic [WORD_SIZE-1:0] word_d;
  logic [MW-1:0] sh_d;
  logic done;

  generate
    if (MSB_FIRST) begin : g_msb
      assign word_d = sh_q[MW-1 -: WORD_SIZE];
      assign sh_d = sh_q << WORD_SIZE;
    end else begin : g_lsb
      assign word_d = sh_q[WORD_SIZE-1:0];
      assign sh_d = sh_q >> WORD_SIZE;
    end
  endgenerate

  msg_rx_framer #(
    .WORD_SIZE(WORD_SIZE),
    .WORDS_PER_PACKET(WORDS_PER_PACKET),
    .INTERBYTE_TIMEOUT(INTERBYTE_TIMEOUT)
  ) u_framer (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .resp_data(resp_data),
    .resp_valid(done),
    .frag_drop(frag_drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      arm_q <= 1'b0;
      low_q <= 1'b0;
      rdy_q <= 1'b0;
      start_q <= 1'b0;
      txd_q <= '0;
      to_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      to_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (cmd_valid && rdy_q) begin
            sh_q <= cmd_data;
            wcnt_q <= '0;
            arm_q <= 1'b1;
            low_q <= 1'b0;
            rdy_q <= 1'b0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (tx_ready && arm_q) begin
            start_q <= 1'b1;
            txd_q <= word_d;
            sh_q <= sh_d;
            arm_q <= 1'b0;
            low_q <= 1'b0;
            wcnt_q <= wcnt_q + 1'b1;
            if (wcnt_q == WC_LAST) begin
              rcnt_q <= '0;
              state_q <= WAIT_RESP;
            end
          end else if (!arm_q) begin
            // Re-arm only after uart_tx has visibly gone
            // busy and come back, so a late-falling ready
            // cannot trigger a second start.
            if (!tx_ready) begin
              low_q <= 1'b1;
            end else if (low_q) begin
              arm_q <= 1'b1;
              low_q <= 1'b0;
            end
          end
        end
        WAIT_RESP: begin
          rcnt_q <= rcnt_q + 1'b1;
          if (done) begin
            rdy_q <= 1'b1;
            state_q <= IDLE;
          end else if (rcnt_q == RC_LAST) begin
            to_q <= 1'b1;
            rdy_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = rdy_q;
  assign tx_start = start_q;
  assign tx_data = txd_q;
  assign resp_valid = done;
  assign resp_timeout = to_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_host_msg_port.sv
// Self-checking bench for host_msg_port against a queue-based
// behavioural model, plus directed and random stimulus.
module tb_host_msg_port;

  localparam int WS = 8;
  localparam int WPP = 4;
  localparam int IT = 100;
  localparam int RT = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] cmd_data = '0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic tx_ready = 1'b1;
  logic tx_start;
  logic [7:0] tx_data;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic [31:0] resp_data;
  logic resp_valid;
  logic resp_timeout;
  logic frag_drop;
  logic busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  host_msg_port #(
    .WORD_SIZE(WS),
    .WORDS_PER_PACKET(WPP),
    .INTERBYTE_TIMEOUT(IT),
    .RESP_TIMEOUT(RT)
  ) dut (
    .clk(clk),
    .reset(rst),
    .cmd_data(cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .tx_ready(tx_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .resp_data(resp_data),
    .resp_valid(resp_valid),
    .resp_timeout(resp_timeout),
    .frag_drop(frag_drop),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // uart_tx stand-in: ready falls one cycle after a start
  // and stays low for 20 cycles.
  bit dly = 0;
  int ucnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      tx_ready = 1'b1;
      dly = 0;
      ucnt = 0;
    end else begin
      if (tx_start)
        chk("start_while_busy", {63'd0, dly || !tx_ready}, 0);
      if (dly) begin
        dly = 0;
        tx_ready = 1'b0;
        ucnt = 20;
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) tx_ready = 1'b1;
      end
      if (tx_start) dly = 1;
    end
  end

  // Behavioural model state.
  logic [7:0] txq[$];
  bit waiting, armed, saw_low;
  int elapsed;
  logic [7:0] rxq[$];
  int gap;
  bit m_ready, m_start, m_to, m_rv, m_fd;
  logic [7:0] m_txd;
  logic [31:0] m_rd;
  bit old_rv;

  // Event log for the directed checks.
  int n_start = 0, n_to = 0, n_fd = 0, n_rv = 0;
  int last_start_cyc = 0, to_cyc = 0;
  logic [7:0] txw[$];

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    waiting = 0; armed = 0; saw_low = 0;
    elapsed = 0; gap = 0;
    m_ready = 0; m_start = 0; m_to = 0;
    m_rv = 0; m_fd = 0; m_txd = '0; m_rd = '0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      chk("rst_cmd_ready", {63'd0, cmd_ready}, 0);
      chk("rst_tx_start", {63'd0, tx_start}, 0);
      chk("rst_tx_data", {56'd0, tx_data}, 0);
      chk("rst_resp_data", {32'd0, resp_data}, 0);
      chk("rst_resp_valid", {63'd0, resp_valid}, 0);
      chk("rst_timeout", {63'd0, resp_timeout}, 0);
      chk("rst_frag", {63'd0, frag_drop}, 0);
      chk("rst_busy", {63'd0, busy}, 0);
    end else begin
      chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, m_ready});
      chk("busy", {63'd0, busy},
          {63'd0, (txq.size() != 0) || waiting});
      chk("tx_start", {63'd0, tx_start}, {63'd0, m_start});
      chk("tx_data", {56'd0, tx_data}, {56'd0, m_txd});
      chk("resp_valid", {63'd0, resp_valid}, {63'd0, m_rv});
      chk("resp_data", {32'd0, resp_data}, {32'd0, m_rd});
      chk("resp_timeout", {63'd0, resp_timeout},
          {63'd0, m_to});
      chk("frag_drop", {63'd0, frag_drop}, {63'd0, m_fd});

      if (tx_start) begin
        n_start++;
        last_start_cyc = cyc;
        txw.push_back(tx_data);
      end
      if (resp_timeout) begin
        n_to++;
        to_cyc = cyc;
      end
      if (frag_drop) n_fd++;
      if (resp_valid) n_rv++;

      // Predict the outputs after the coming clock edge.
      old_rv = m_rv;
      m_start = 0;
      m_to = 0;
      if (txq.size() == 0 && !waiting) begin
        if (cmd_valid && m_ready) begin
          for (int i = WPP - 1; i >= 0; i--)
            txq.push_back(cmd_data[i*WS +: WS]);
          armed = 1;
          saw_low = 0;
        end
      end else if (txq.size() != 0) begin
        if (tx_ready && armed) begin
          m_start = 1;
          m_txd = txq.pop_front();
          armed = 0;
          saw_low = 0;
          if (txq.size() == 0) begin
            waiting = 1;
            elapsed = 0;
          end
        end else if (!armed) begin
          if (!tx_ready) saw_low = 1;
          else if (saw_low) armed = 1;
        end
      end else begin
        if (old_rv) waiting = 0;
        else if (elapsed == RT - 1) begin
          m_to = 1;
          waiting = 0;
        end else elapsed++;
      end
      m_ready = (txq.size() == 0) && !waiting;

      m_rv = 0;
      m_fd = 0;
      if (rx_valid) begin
        rxq.push_back(rx_data);
        gap = 0;
        if (rxq.size() == WPP) begin
          m_rd = '0;
          foreach (rxq[i]) m_rd = {m_rd[23:0], rxq[i]};
          m_rv = 1;
          rxq.delete();
        end
      end else if (rxq.size() != 0) begin
        if (gap == IT - 1) begin
          m_fd = 1;
          rxq.delete();
          gap = 0;
        end else gap++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 3000) begin
      tick(1);
      n++;
    end
    chk("wait_idle_bound", {63'd0, cmd_ready}, 1);
  endtask

  task automatic send_cmd(input logic [31:0] d);
    cmd_data = d;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (n_start < target && n < 2000) begin
      tick(1);
      n++;
    end
    chk("start_wait_bound", {63'd0, n_start >= target}, 1);
  endtask

  task automatic rx_word(input logic [7:0] w);
    rx_valid = 1'b1;
    rx_data = w;
    tick(1);
    rx_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int s0, t0, f0, r0, n;
    logic [7:0] e1[4];
    e1[0] = 8'hDE; e1[1] = 8'hAD;
    e1[2] = 8'hBE; e1[3] = 8'hEF;

    tick(3);
    chk("in_reset_ready", {63'd0, cmd_ready}, 0);
    rst = 1'b0;
    tick(2);
    chk("post_reset_ready", {63'd0, cmd_ready}, 1);

    // 1: command split MSB first.
    wait_idle();
    s0 = n_start;
    send_cmd(32'hDEADBEEF);
    wait_starts(s0 + 4);
    for (int i = 0; i < 4; i++)
      if (txw.size() > s0 + i)
        chk("t1_word", {56'd0, txw[s0+i]}, {56'd0, e1[i]});
    tick(30);
    chk("t1_count", n_start - s0, 4);

    // 2: response ends the wait.
    r0 = n_rv;
    t0 = n_to;
    rx_word(8'h12); rx_word(8'h34);
    rx_word(8'h56); rx_word(8'h78);
    tick(3);
    chk("t2_data", {32'd0, resp_data}, 64'h12345678);
    chk("t2_nrv", n_rv - r0, 1);
    chk("t2_busy", {63'd0, busy}, 0);
    chk("t2_ready", {63'd0, cmd_ready}, 1);
    chk("t2_noto", n_to - t0, 0);

    // 3a: no reply -> timeout after RT wait cycles.
    wait_idle();
    s0 = n_start;
    t0 = n_to;
    send_cmd(32'h11223344);
    wait_starts(s0 + 4);
    n = 0;
    while (n_to == t0 && n < 1500) begin
      tick(1);
      n++;
    end
    chk("t3_nto", n_to - t0, 1);
    chk("t3_latency", to_cyc - last_start_cyc, 1000);
    tick(2);
    chk("t3_ready", {63'd0, cmd_ready}, 1);

    // 3b: reply completes on the expiry cycle.
    wait_idle();
    s0 = n_start;
    t0 = n_to;
    r0 = n_rv;
    send_cmd(32'h55667788);
    wait_starts(s0 + 4);
    n = 0;
    while (cyc < last_start_cyc + 995 && n < 1500) begin
      tick(1);
      n++;
    end
    rx_word(8'h9A); rx_word(8'hBC);
    rx_word(8'hDE); rx_word(8'hF0);
    tick(5);
    chk("t3b_noto", n_to - t0, 0);
    chk("t3b_nrv", n_rv - r0, 1);
    chk("t3b_data", {32'd0, resp_data}, 64'h9ABCDEF0);
    chk("t3b_busy", {63'd0, busy}, 0);

    // 4: partial message dropped after IT idle cycles.
    f0 = n_fd;
    rx_word(8'hAA); rx_word(8'hBB);
    tick(100);
    chk("t4_nodrop_yet", n_fd - f0, 0);
    tick(2);
    chk("t4_drop", n_fd - f0, 1);
    rx_word(8'h01); rx_word(8'h02);
    rx_word(8'h03); rx_word(8'h04);
    tick(3);
    chk("t4_data", {32'd0, resp_data}, 64'h01020304);

    // 5: word on the expiry cycle is kept.
    f0 = n_fd;
    rx_word(8'hAA);
    tick(99);
    rx_word(8'hBB); rx_word(8'hCC); rx_word(8'hDD);
    tick(3);
    chk("t5_nodrop", n_fd - f0, 0);
    chk("t5_data", {32'd0, resp_data}, 64'hAABBCCDD);

    // 6: reset in the middle of a send.
    wait_idle();
    s0 = n_start;
    send_cmd(32'hCAFEF00D);
    wait_starts(s0 + 2);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_txd", {56'd0, tx_data}, 0);
    tick(2);
    rst = 1'b0;
    s0 = n_start;
    t0 = n_to;
    f0 = n_fd;
    tick(300);
    chk("t6_nostart", n_start - s0, 0);
    chk("t6_noto", n_to - t0, 0);
    chk("t6_nofrag", n_fd - f0, 0);
    chk("t6_ready", {63'd0, cmd_ready}, 1);

    // Random traffic: commands offered at any time, bursts
    // of words with short or near-limit gaps.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        cmd_data = $urandom;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
      end
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
        rx_word(8'($urandom));
        if ($urandom_range(0, 5) == 0)
          tick($urandom_range(95, 105));
        else
          tick($urandom_range(0, 2));
      end
      tick($urandom_range(1, 1100));
    end

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
